serial_adder_ctrl: RTL and testbench

Bit-serial adder controller. It time-multiplexes one `full_adder` cell over WIDTH-bit operands, one bit per clock, LSB first, with the carry held in a flop between bits. It takes operands through a valid/ready start handshake and returns sum and carry-out through a valid/ready done handshake. It is the area-minimal alternative to a WIDTH-wide ripple adder, for low-throughput arithmetic paths.

---
 rtl/serial_add_pkg.sv | 7 +
 rtl/full_adder.sv | 11 +
 rtl/serial_adder_ctrl.sv | 76 +++++++
 tb/tb_serial_adder_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state encoding and counter-width helper for the bit-serial adder
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  function automatic int cnt_w(input int w);
    return w <= 1 ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell; ports a, b, cin -> sum, cout
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder over one full_adder; start (start_valid/start_ready, a, b, cin) and done (done_valid/done_ready, sum, cout) handshakes, busy flag; clk, async active-low rst_n
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_sh_q, sum_sh_d;
  logic [WIDTH:0]   sum_cat;
  logic             carry_q, carry_d, s, co;
  logic [CW-1:0]    cnt_q, cnt_d;
  full_adder u_fa (.a(a_sh_q[0]), .b(b_sh_q[0]), .cin(carry_q), .sum(s), .cout(co));
  // new sum bit enters at the MSB; written this way so WIDTH=1 needs no empty slice
  assign sum_cat = {s, sum_sh_q};
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    if (state_q == IDLE && start_valid) begin
      a_sh_d   = a;
      b_sh_d   = b;
      carry_d  = cin;
      cnt_d    = '0;
      sum_sh_d = '0;
      state_d  = RUN;
    end else if (state_q == RUN) begin
      sum_sh_d = sum_cat[WIDTH:1];
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      carry_d  = co;
      cnt_d    = cnt_q + CW'(1);
      state_d  = cnt_q == CW'(WIDTH - 1) ? DONE : RUN;
    end else if (state_q == DONE && done_ready) begin
      state_d  = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end
  assign start_ready = state_q == IDLE;
  assign done_valid  = state_q == DONE;
  assign busy        = state_q != IDLE;
  assign sum         = sum_sh_q;
  assign cout        = carry_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1
module tb_serial_adder_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start_valid = 1'b0, done_ready = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       start_ready, done_valid, cout, busy;
  logic [7:0] sum;
  logic       sv1 = 1'b0, dr1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       sr1, dv1, co1, bz1;
  logic [0:0] s1;
  int         checks = 0, failures = 0;
  always #5 clk = ~clk;
  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .cin(cin), .done_valid(done_valid), .done_ready(done_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );
  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
    .a(a1), .b(b1), .cin(c1), .done_valid(dv1), .done_ready(dr1),
    .sum(s1), .cout(co1), .busy(bz1)
  );
  // one full operation; lat counts rising edges from the accepting edge (inclusive) to done_valid
  task automatic do_op(input logic [7:0] ia, ib, input logic ic,
                       output logic [8:0] res, output int lat, output logic [2:0] flags);
    int n;
    @(negedge clk);
    a = ia; b = ib; cin = ic; start_valid = 1'b1; done_ready = 1'b0;
    n = 0;
    while (!start_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start_valid = 1'b0;
    while (!done_valid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    res = {cout, sum};
    flags = {busy, start_ready, done_valid};
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
  endtask
  task automatic test_reset;
    #1;
    checks++;
    if ({sum, cout, done_valid, busy, start_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset8 got sum=%h cout=%b dv=%b busy=%b sr=%b want 00 0 0 0 1", sum, cout, done_valid, busy, start_ready);
    end
    checks++;
    if ({s1, co1, dv1, bz1, sr1} !== 5'b00001) begin
      failures++;
      $display("FAIL reset1 got %b want 00001", {s1, co1, dv1, bz1, sr1});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_directed;
    logic [8:0] res, exp;
    logic [2:0] fl;
    int lat;
    logic [16:0] vec [3] = '{{8'h5A, 8'h33, 1'b0}, {8'hFF, 8'h01, 1'b0}, {8'hFF, 8'hFF, 1'b1}};
    foreach (vec[i]) begin
      exp = {1'b0, vec[i][16:9]} + {1'b0, vec[i][8:1]} + {8'h00, vec[i][0]};
      do_op(vec[i][16:9], vec[i][8:1], vec[i][0], res, lat, fl);
      checks++;
      if (res !== exp) begin failures++; $display("FAIL directed_sum[%0d] got %h want %h", i, res, exp); end
      checks++;
      if (lat != 9) begin failures++; $display("FAIL directed_latency[%0d] got %0d want 9", i, lat); end
      checks++;
      if (fl !== 3'b101) begin failures++; $display("FAIL directed_flags[%0d] got %b want 101", i, fl); end
    end
  endtask
  task automatic test_backpressure;
    logic [8:0] res, held;
    logic [2:0] fl;
    int lat;
    do_op(8'h12, 8'h34, 1'b1, res, lat, fl);
    @(negedge clk);
    a = 8'h80; b = 8'h90; cin = 1'b0; start_valid = 1'b1; done_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    lat = 0;
    while (!done_valid && lat < 50) begin @(negedge clk); lat++; end
    held = {cout, sum};
    checks++;
    if (held !== 9'h110) begin failures++; $display("FAIL bp_result got %h want 110", held); end
    for (int k = 0; k < 5; k++) begin
      start_valid = ~start_valid; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({cout, sum} !== held || start_ready !== 1'b0 || done_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d] got res=%h sr=%b dv=%b want res=%h sr=0 dv=1", k, {cout, sum}, start_ready, done_valid, held);
      end
    end
    a = 8'h10; b = 8'h20; cin = 1'b0; start_valid = 1'b1; done_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({start_ready, done_valid, busy} !== 3'b100) begin
      failures++; $display("FAIL bp_idle got sr/dv/busy=%b want 100", {start_ready, done_valid, busy});
    end
    @(negedge clk);
    checks++;
    if ({start_ready, busy} !== 2'b01) begin
      failures++; $display("FAIL bp_accept got sr/busy=%b want 01", {start_ready, busy});
    end
    start_valid = 1'b0; done_ready = 1'b0;
    lat = 0;
    while (!done_valid && lat < 50) begin @(negedge clk); lat++; end
    checks++;
    if ({cout, sum} !== 9'h030) begin failures++; $display("FAIL bp_next got %h want 030", {cout, sum}); end
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
  endtask
  task automatic test_reset_mid;
    logic [8:0] res;
    logic [2:0] fl;
    int lat, seen;
    @(negedge clk);
    a = 8'hAB; b = 8'hCD; cin = 1'b1; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sum, cout, done_valid, busy, start_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL midreset got sum=%h cout=%b dv=%b busy=%b sr=%b want 00 0 0 0 1", sum, cout, done_valid, busy, start_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin @(negedge clk); seen += int'(done_valid); end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midreset_nodone got %0d done cycles want 0", seen); end
    do_op(8'h10, 8'h20, 1'b0, res, lat, fl);
    checks++;
    if (res !== 9'h030) begin failures++; $display("FAIL midreset_next got %h want 030", res); end
  endtask
  task automatic test_width1;
    int lat;
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; sv1 = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    sv1 = 1'b0;
    while (!dv1 && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    checks++;
    if ({co1, s1} !== 2'b11) begin failures++; $display("FAIL w1_result got %b want 11", {co1, s1}); end
    checks++;
    if (lat != 2) begin failures++; $display("FAIL w1_latency got %0d want 2", lat); end
    dr1 = 1'b1;
    @(negedge clk);
    dr1 = 1'b0;
    checks++;
    if ({sr1, dv1} !== 2'b10) begin failures++; $display("FAIL w1_idle got %b want 10", {sr1, dv1}); end
  endtask
  task automatic test_random;
    logic [8:0] q[$];
    logic [8:0] exp, last;
    logic       p_sv, p_sr, p_dv, p_dr;
    int         accepts = 0, results = 0, cyc = 0, bad = 0;
    @(negedge clk);
    start_valid = 1'b0; done_ready = 1'b0;
    p_sv = 0; p_sr = start_ready; p_dv = done_valid; p_dr = 0; last = {cout, sum};
    while ((accepts < 1000 || q.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (p_sv && p_sr) begin
        q.push_back({1'b0, a} + {1'b0, b} + {8'h00, cin});
        accepts++;
      end
      if (p_dv && p_dr) begin
        exp = q.size() != 0 ? q.pop_front() : 9'hxxx;
        results++;
        checks++;
        if (last !== exp) begin failures++; $display("FAIL random_result[%0d] got %h want %h", results, last, exp); end
      end else if (p_dv && done_valid && {cout, sum} !== last && bad < 5) begin
        bad++;
        checks++; failures++;
        $display("FAIL random_hold got %h want %h", {cout, sum}, last);
      end
      if (!start_valid || (p_sv && p_sr)) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        start_valid = accepts < 1000 && $urandom_range(0, 3) != 0;
      end
      done_ready = $urandom_range(0, 2) == 0;
      p_sv = start_valid; p_sr = start_ready; p_dv = done_valid; p_dr = done_ready;
      last = {cout, sum};
    end
    start_valid = 1'b0; done_ready = 1'b0;
    checks++;
    if (accepts != 1000 || results != accepts) begin
      failures++; $display("FAIL random_count got accepts=%0d results=%0d want 1000 1000", accepts, results);
    end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid;
    test_width1;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
